// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register of DEPTH stages with valid/ready handshake, flush and stall counting.
// All state changes on the falling edge of clk; rst is synchronous.
module pipe_stage_reg #(
  parameter int DATA_W         = 107,
  parameter int DEPTH          = 1,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [2:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  adv;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [2:0]        occ_q, occ_d;
  logic [15:0]       stall_q, stall_d;
  logic              in_fire;

  // A stage advances when it holds an item and the slot ahead is empty or itself advancing.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = valid_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = valid_q[i] & (~valid_q[i+1] | adv[i+1]);
    end
    in_ready = (~valid_q[0] | adv[0]) & ~flush;
    in_fire  = in_valid & in_ready;
  end

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    stall_d = stall_q;
    if (valid_q[DEPTH-1] && !out_ready && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    if (flush) begin
      valid_d = '0;
      if (CLEAR_ON_FLUSH) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = '0;
        end
      end
    end else begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (adv[i-1]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_q[i-1];
        end else if (adv[i]) begin
          valid_d[i] = 1'b0;
          if (CLEAR_ON_FLUSH) data_d[i] = '0;
        end
      end
      if (in_fire) begin
        valid_d[0] = 1'b1;
        data_d[0]  = in_data;
      end else if (adv[0]) begin
        valid_d[0] = 1'b0;
        if (CLEAR_ON_FLUSH) data_d[0] = '0;
      end
    end

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + 3'(valid_d[i]);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized plus directed bench for pipe_stage_reg; three instances of differing depth and
// flush behaviour share the same stimulus and are compared against a slot-shifting model.
module tb_pipe_stage_reg;

  localparam int NI = 3;
  localparam int DEP [NI] = '{3, 1, 2};
  localparam bit CLR [NI] = '{1'b1, 1'b0, 1'b1};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;

  logic [NI-1:0]       ir;
  logic [NI-1:0]       ov;
  logic [NI-1:0][15:0] od;
  logic [NI-1:0][2:0]  occ;
  logic [NI-1:0][15:0] sc;

  bit          mv [NI][4];
  logic [15:0] md [NI][4];
  int          mst [NI];

  int nChecks = 0;
  int nFails  = 0;

  pipe_stage_reg #(.DATA_W(16), .DEPTH(3), .CLEAR_ON_FLUSH(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[0]), .stall_cnt(sc[0]));

  pipe_stage_reg #(.DATA_W(16), .DEPTH(1), .CLEAR_ON_FLUSH(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[1]), .stall_cnt(sc[1]));

  pipe_stage_reg #(.DATA_W(16), .DEPTH(2), .CLEAR_ON_FLUSH(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .flush(flush),
    .occupancy(occ[2]), .stall_cnt(sc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the rising edge, predict in_ready, let the falling edge
  // update state, then compare registered outputs against the model.
  task automatic applyStimulus(input bit r, input bit f, input bit iv, input logic [15:0] id,
                               input bit ordy, input bit doCheck);
    bit          cv [NI][4];
    logic [15:0] cd [NI][4];
    bit          expReady [NI];
    bit          stallEdge [NI];
    int          cnt;
    int          last;
    rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    for (int k = 0; k < NI; k++) begin
      last = DEP[k] - 1;
      for (int i = 0; i < 4; i++) begin
        cv[k][i] = mv[k][i];
        cd[k][i] = md[k][i];
      end
      stallEdge[k] = mv[k][last] && !ordy && !f;
      if (cv[k][last] && ordy) begin
        cv[k][last] = 1'b0;
        cd[k][last] = '0;
      end
      for (int i = last - 1; i >= 0; i--) begin
        if (cv[k][i] && !cv[k][i+1]) begin
          cv[k][i+1] = 1'b1;
          cd[k][i+1] = cd[k][i];
          cv[k][i]   = 1'b0;
          cd[k][i]   = '0;
        end
      end
      expReady[k] = !f && !cv[k][0];
    end
    #1;
    if (doCheck && !r) begin
      for (int k = 0; k < NI; k++) begin
        checkOutput($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(expReady[k]));
      end
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (r) begin
        for (int i = 0; i < 4; i++) begin
          mv[k][i] = 1'b0;
          md[k][i] = '0;
        end
        mst[k] = 0;
      end else begin
        if (stallEdge[k] && mst[k] < 65535) mst[k]++;
        if (f) begin
          for (int i = 0; i < 4; i++) begin
            mv[k][i] = 1'b0;
            if (CLR[k]) md[k][i] = '0;
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            mv[k][i] = cv[k][i];
            md[k][i] = cd[k][i];
          end
          if (iv && expReady[k]) begin
            mv[k][0] = 1'b1;
            md[k][0] = id;
          end
        end
      end
    end
    #1;
    if (doCheck) begin
      for (int k = 0; k < NI; k++) begin
        last = DEP[k] - 1;
        cnt = 0;
        for (int i = 0; i < DEP[k]; i++) cnt += int'(mv[k][i]);
        checkOutput($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(mv[k][last]));
        checkOutput($sformatf("occupancy[%0d]", k), 32'(occ[k]), 32'(cnt));
        checkOutput($sformatf("stall_cnt[%0d]", k), 32'(sc[k]), 32'(mst[k]));
        if (CLR[k] || mv[k][last] || r) begin
          checkOutput($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(md[k][last]));
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < NI; k++) begin
      mst[k] = 0;
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = '0;
      end
    end

    applyStimulus(1, 0, 0, 16'h0, 1, 1);
    applyStimulus(1, 0, 0, 16'h0, 1, 1);

    // Streaming at full rate: sequential payloads must emerge in order with no bubbles.
    for (int n = 1; n <= 8; n++) applyStimulus(0, 0, 1, 16'(n), 1, 1);
    for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 16'h0, 1, 1);

    // Backpressure fill: five offers with downstream stalled, then drain.
    applyStimulus(1, 0, 0, 16'h0, 0, 1);
    for (int n = 0; n < 5; n++) applyStimulus(0, 0, 1, 16'h10 + 16'(n), 0, 1);
    for (int n = 0; n < 5; n++) applyStimulus(0, 0, 0, 16'h0, 1, 1);

    // Flush of full stages while a new item is offered.
    for (int n = 0; n < 3; n++) applyStimulus(0, 0, 1, 16'h20 + 16'(n), 0, 1);
    applyStimulus(0, 1, 1, 16'hAA, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 1, 1);

    // Reset colliding with flush and an offered item mid-stall.
    for (int n = 0; n < 3; n++) applyStimulus(0, 0, 1, 16'h30 + 16'(n), 0, 1);
    applyStimulus(1, 1, 1, 16'h55, 1, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom % 97) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                    16'($urandom), (n % 400 < 200) ? (($urandom % 3) != 0) : (($urandom % 4) == 0), 1);
    end

    // Long stall: the counter must pin at its maximum rather than wrap.
    applyStimulus(1, 0, 0, 16'h0, 0, 1);
    applyStimulus(0, 0, 1, 16'hBEEF, 0, 1);
    for (int n = 0; n < 70000; n++) applyStimulus(0, 0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 0, 1);
    applyStimulus(0, 0, 0, 16'h0, 0, 1);
    applyStimulus(0, 1, 0, 16'h0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
